// File: rtl/stopwatch_core_bcd.sv
// BCD stopwatch / countdown core: minutes, seconds, fraction as two-digit BCD fields,
// with preset load, synchronous clear, lap capture and a registered wrap pulse.
module stopwatch_core_bcd #(
  parameter logic [7:0] FRAC_MAX     = 8'h99,
  parameter logic [7:0] SEC_MAX      = 8'h59,
  parameter logic [7:0] MIN_MAX      = 8'h59,
  parameter bit         STOP_AT_ZERO = 1'b1
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic [7:0] load_frac,
  input  logic       lap,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] frac_o,
  output logic [7:0] lap_min_o,
  output logic [7:0] lap_sec_o,
  output logic [7:0] lap_frac_o,
  output logic       lap_valid_o,
  output logic       wrap_o,
  output logic       zero_o
);

  logic [7:0] min_q, min_d, sec_q, sec_d, frac_q, frac_d;
  logic [7:0] lap_min_q, lap_sec_q, lap_frac_q;
  logic       lap_valid_q, wrap_q, wrap_d;

  // Clamp each digit to 9, then the whole field to its terminal value.
  function automatic logic [7:0] bcd_sat(input logic [7:0] v, input logic [7:0] mx);
    logic [3:0] hi, lo;
    logic [7:0] r;
    hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    r  = {hi, lo};
    return (r > mx) ? mx : r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    min_d  = min_q;
    sec_d  = sec_q;
    frac_d = frac_q;
    wrap_d = 1'b0;
    if (clr) begin
      min_d  = 8'h00;
      sec_d  = 8'h00;
      frac_d = 8'h00;
    end else if (load) begin
      min_d  = bcd_sat(load_min, MIN_MAX);
      sec_d  = bcd_sat(load_sec, SEC_MAX);
      frac_d = bcd_sat(load_frac, FRAC_MAX);
    end else if (en) begin
      if (!dir) begin
        // BCD ordering matches binary ordering, so plain compares are safe here.
        if (frac_q < FRAC_MAX) begin
          frac_d = bcd_inc(frac_q);
        end else begin
          frac_d = 8'h00;
          if (sec_q < SEC_MAX) begin
            sec_d = bcd_inc(sec_q);
          end else begin
            sec_d = 8'h00;
            if (min_q < MIN_MAX) begin
              min_d = bcd_inc(min_q);
            end else begin
              min_d  = 8'h00;
              wrap_d = 1'b1;
            end
          end
        end
      end else begin
        if (frac_q != 8'h00) begin
          frac_d = bcd_dec(frac_q);
        end else begin
          frac_d = FRAC_MAX;
          if (sec_q != 8'h00) begin
            sec_d = bcd_dec(sec_q);
          end else begin
            sec_d = SEC_MAX;
            if (min_q != 8'h00) begin
              min_d = bcd_dec(min_q);
            end else if (STOP_AT_ZERO) begin
              min_d  = 8'h00;
              sec_d  = 8'h00;
              frac_d = 8'h00;
            end else begin
              min_d  = MIN_MAX;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      frac_q      <= 8'h00;
      wrap_q      <= 1'b0;
      lap_min_q   <= 8'h00;
      lap_sec_q   <= 8'h00;
      lap_frac_q  <= 8'h00;
      lap_valid_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      sec_q  <= sec_d;
      frac_q <= frac_d;
      wrap_q <= wrap_d;
      if (clr) begin
        lap_min_q   <= 8'h00;
        lap_sec_q   <= 8'h00;
        lap_frac_q  <= 8'h00;
        lap_valid_q <= 1'b0;
      end else if (lap) begin
        // Captures the pre-update count, even when a load lands in the same cycle.
        lap_min_q   <= min_q;
        lap_sec_q   <= sec_q;
        lap_frac_q  <= frac_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign min_o       = min_q;
  assign sec_o       = sec_q;
  assign frac_o      = frac_q;
  assign lap_min_o   = lap_min_q;
  assign lap_sec_o   = lap_sec_q;
  assign lap_frac_o  = lap_frac_q;
  assign lap_valid_o = lap_valid_q;
  assign wrap_o      = wrap_q;
  assign zero_o      = (min_q == 8'h00) && (sec_q == 8'h00) && (frac_q == 8'h00);

endmodule

// File: tb/tb_stopwatch_core_bcd.sv
// Directed bench for stopwatch_core_bcd; a second instance with STOP_AT_ZERO=0
// shares the stimulus to cover countdown wrap.
module tb_stopwatch_core_bcd;

  logic       clk_core = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, clr = 1'b0, dir = 1'b0, load = 1'b0, lap = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00, load_frac = 8'h00;

  logic [7:0] min_o, sec_o, frac_o, lap_min_o, lap_sec_o, lap_frac_o;
  logic       lap_valid_o, wrap_o, zero_o;
  logic [7:0] w_min_o, w_sec_o, w_frac_o, w_lap_min_o, w_lap_sec_o, w_lap_frac_o;
  logic       w_lap_valid_o, w_wrap_o, w_zero_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_core = ~clk_core;

  stopwatch_core_bcd dut (
    .clk_core(clk_core), .rst(rst), .en(en), .clr(clr), .dir(dir), .load(load),
    .load_min(load_min), .load_sec(load_sec), .load_frac(load_frac), .lap(lap),
    .min_o(min_o), .sec_o(sec_o), .frac_o(frac_o),
    .lap_min_o(lap_min_o), .lap_sec_o(lap_sec_o), .lap_frac_o(lap_frac_o),
    .lap_valid_o(lap_valid_o), .wrap_o(wrap_o), .zero_o(zero_o)
  );

  stopwatch_core_bcd #(.STOP_AT_ZERO(1'b0)) dut_w (
    .clk_core(clk_core), .rst(rst), .en(en), .clr(clr), .dir(dir), .load(load),
    .load_min(load_min), .load_sec(load_sec), .load_frac(load_frac), .lap(lap),
    .min_o(w_min_o), .sec_o(w_sec_o), .frac_o(w_frac_o),
    .lap_min_o(w_lap_min_o), .lap_sec_o(w_lap_sec_o), .lap_frac_o(w_lap_frac_o),
    .lap_valid_o(w_lap_valid_o), .wrap_o(w_wrap_o), .zero_o(w_zero_o)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s, input logic [7:0] f);
    load = 1'b1; load_min = m; load_sec = s; load_frac = f;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({min_o, sec_o, frac_o} !== 24'h000000) begin
      errors++; $display("FAIL reset_count: got %h want 000000", {min_o, sec_o, frac_o});
    end
    checks++;
    if ({zero_o, wrap_o, lap_valid_o} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got %b want 100", {zero_o, wrap_o, lap_valid_o});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    logic wrap_seen;
    wrap_seen = 1'b0;
    dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      tick();
      wrap_seen |= wrap_o;
    end
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o} !== 24'h010000) begin
      errors++; $display("FAIL up_6000: got %h want 010000", {min_o, sec_o, frac_o});
    end
    checks++;
    if (wrap_seen !== 1'b0) begin
      errors++; $display("FAIL up_no_wrap: got %b want 0", wrap_seen);
    end
  endtask

  task automatic test_up_wrap();
    do_load(8'h59, 8'h59, 8'h98);
    en = 1'b1;
    tick();
    checks++;
    if ({min_o, sec_o, frac_o, wrap_o} !== {24'h595999, 1'b0}) begin
      errors++; $display("FAIL up_pre_wrap: got %h/%b want 595999/0", {min_o, sec_o, frac_o}, wrap_o);
    end
    tick();
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o, wrap_o} !== {24'h000000, 1'b1}) begin
      errors++; $display("FAIL up_wrap: got %h/%b want 000000/1", {min_o, sec_o, frac_o}, wrap_o);
    end
    tick();
    checks++;
    if (wrap_o !== 1'b0) begin
      errors++; $display("FAIL up_wrap_pulse: got %b want 0", wrap_o);
    end
  endtask

  task automatic test_count_down();
    do_load(8'h01, 8'h00, 8'h00);
    dir = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o} !== 24'h005999) begin
      errors++; $display("FAIL down_borrow: got %h want 005999", {min_o, sec_o, frac_o});
    end
    do_load(8'h00, 8'h00, 8'h01);
    en = 1'b1;
    tick();
    checks++;
    if ({min_o, sec_o, frac_o, zero_o} !== {24'h000000, 1'b1}) begin
      errors++; $display("FAIL down_to_zero: got %h/%b want 000000/1", {min_o, sec_o, frac_o}, zero_o);
    end
    tick();
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o, zero_o, wrap_o} !== {24'h000000, 2'b10}) begin
      errors++; $display("FAIL down_hold: got %h/%b%b want 000000/10", {min_o, sec_o, frac_o}, zero_o, wrap_o);
    end
    checks++;
    if ({w_min_o, w_sec_o, w_frac_o, w_wrap_o} !== {24'h595999, 1'b1}) begin
      errors++; $display("FAIL down_wrap: got %h/%b want 595999/1", {w_min_o, w_sec_o, w_frac_o}, w_wrap_o);
    end
    tick();
    checks++;
    if (w_wrap_o !== 1'b0) begin
      errors++; $display("FAIL down_wrap_pulse: got %b want 0", w_wrap_o);
    end
    // Direction flips back to up: next step goes forward by exactly one.
    dir = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o} !== 24'h000001) begin
      errors++; $display("FAIL dir_change: got %h want 000001", {min_o, sec_o, frac_o});
    end
  endtask

  task automatic test_load_sat();
    en = 1'b1;  // ignored during load
    do_load(8'h9F, 8'h7A, 8'h3C);
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o} !== 24'h595939) begin
      errors++; $display("FAIL load_sat: got %h want 595939", {min_o, sec_o, frac_o});
    end
  endtask

  task automatic test_lap();
    do_load(8'h00, 8'h12, 8'h33);
    dir = 1'b0; en = 1'b1;
    tick();
    lap = 1'b1;
    tick();
    lap = 1'b0; en = 1'b0;
    checks++;
    if ({lap_min_o, lap_sec_o, lap_frac_o, lap_valid_o} !== {24'h001234, 1'b1}) begin
      errors++; $display("FAIL lap_capture: got %h/%b want 001234/1",
                         {lap_min_o, lap_sec_o, lap_frac_o}, lap_valid_o);
    end
    checks++;
    if (frac_o !== 8'h35) begin
      errors++; $display("FAIL lap_count: got %h want 35", frac_o);
    end
    // Lap with load overwrites using the pre-load value.
    lap = 1'b1;
    do_load(8'h07, 8'h08, 8'h09);
    lap = 1'b0;
    checks++;
    if ({lap_min_o, lap_sec_o, lap_frac_o, min_o, sec_o, frac_o} !== 48'h001235_070809) begin
      errors++; $display("FAIL lap_load: got %h want 001235070809",
                         {lap_min_o, lap_sec_o, lap_frac_o, min_o, sec_o, frac_o});
    end
  endtask

  task automatic test_back_to_back();
    clr = 1'b1; en = 1'b1;
    do_load(8'h11, 8'h22, 8'h33);
    clr = 1'b0; en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o, lap_min_o, lap_sec_o, lap_frac_o} !== 48'h0) begin
      errors++; $display("FAIL clr_prio: got %h want 0",
                         {min_o, sec_o, frac_o, lap_min_o, lap_sec_o, lap_frac_o});
    end
    checks++;
    if ({lap_valid_o, wrap_o, zero_o} !== 3'b001) begin
      errors++; $display("FAIL clr_flags: got %b want 001", {lap_valid_o, wrap_o, zero_o});
    end
  endtask

  task automatic test_async_reset();
    dir = 1'b0; en = 1'b1;
    lap = 1'b1;
    tick();
    tick();
    lap = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({min_o, sec_o, frac_o, lap_frac_o, lap_valid_o} !== 33'h0) begin
      errors++; $display("FAIL async_reset: got %h/%h/%b want 000000/00/0",
                         {min_o, sec_o, frac_o}, lap_frac_o, lap_valid_o);
    end
    en = 1'b0;
    #2 rst = 1'b1;
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if ({min_o, sec_o, frac_o} !== 24'h000001) begin
      errors++; $display("FAIL post_reset: got %h want 000001", {min_o, sec_o, frac_o});
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_up_wrap();
    test_count_down();
    test_load_sat();
    test_lap();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_core_bcd.md
Name: stopwatch_core_bcd

Overview:
- Parametrised BCD time counter with three fields: fraction (fastest), seconds, minutes. Each field is two BCD digits.
- Counts up as a stopwatch or down as a countdown timer.
- Supports preset load, synchronous clear, lap capture and event pulses.
- Sits between the tick divider (which drives en at the fraction rate) and the display/mux logic.

Parameters:
- FRAC_MAX, 8'h99, BCD terminal value of the fraction field (8'h99 = centiseconds, 8'h09 = tenths).
- SEC_MAX, 8'h59, BCD terminal value of the seconds field.
- MIN_MAX, 8'h59, BCD terminal value of the minutes field (up to 8'h99).
- STOP_AT_ZERO, 1, in down mode: 1 = hold at all-zero, 0 = wrap to all-max.

Ports:
- clk_core  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  count tick; one step per cycle while high.
- clr  in  1  synchronous clear of count, lap registers and flags.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous preset strobe.
- load_min  in  8  BCD preset for minutes.
- load_sec  in  8  BCD preset for seconds.
- load_frac  in  8  BCD preset for fraction.
- lap  in  1  capture strobe.
- min_o  out  8  minutes {tens, units} in BCD.
- sec_o  out  8  seconds in BCD.
- frac_o  out  8  fraction in BCD.
- lap_min_o  out  8  captured minutes.
- lap_sec_o  out  8  captured seconds.
- lap_frac_o  out  8  captured fraction.
- lap_valid_o  out  1  high once a lap has been captured, until clr.
- wrap_o  out  1  one-cycle pulse on any full-range wrap.
- zero_o  out  1  level, high while the count equals 00:00.00.

Behaviour:
- Reset (rst low, asynchronous): all count, lap and flag outputs go to 0. zero_o is 1 because it is combinational from the count.
- All updates happen on posedge clk_core.
- Priority per cycle: clr > load > en. lap is evaluated in parallel with these.
- clr: count = 0, lap registers = 0, lap_valid_o = 0, wrap_o = 0.
- load: fields take the load_* values.
  - Any digit above 9 is replaced by 9.
  - Any field above its *_MAX is replaced by that *_MAX.
  - en is ignored in a load cycle. wrap_o = 0.
- Up count (en=1, dir=0):
  - If frac < FRAC_MAX, increment frac in BCD: units 9 -> 0 with tens +1.
  - Else frac = 0 and seconds step the same way against SEC_MAX.
  - Else minutes step against MIN_MAX.
  - At MIN_MAX:SEC_MAX:FRAC_MAX, all fields go to 0 and wrap_o pulses for 1 cycle.
- Down count (en=1, dir=1):
  - If frac > 0, decrement frac in BCD: units 0 -> 9 with tens -1.
  - Else frac = FRAC_MAX and borrow from seconds; seconds borrow from minutes the same way.
  - At all-zero with STOP_AT_ZERO=1: hold, no pulse.
  - At all-zero with STOP_AT_ZERO=0: go to all-max and pulse wrap_o.
- dir may change on any cycle. It takes effect on the next en step with no glitch or extra step.
- en=0: hold the count. wrap_o = 0.
- lap=1 (and clr=0):
  - lap_* registers take the count value present before this cycle's update.
  - lap_valid_o goes to 1.
  - lap in the same cycle as load captures the pre-load value.
  - A lap while lap_valid_o is already 1 overwrites the lap registers.
- Latency: outputs reflect an update 1 cycle after the strobe. zero_o is combinational from the count registers.
- Invariant: every digit stays at 9 or below and every field stays at or below its *_MAX at all times.
- Reset asserted mid-count or during a lap clears immediately; no partial state survives.

Test Plan:
- Reset then 6000 en cycles, dir=0, defaults -> min_o=8'h01, sec_o=8'h00, frac_o=8'h00. wrap_o never high.
- load 59:59.98 then 2 en cycles -> 59:59.99, then 00:00.00 with wrap_o high for exactly that cycle.
- load 01:00.00, dir=1, 1 en -> 00:59.99. Then load 00:00.01 and 2 en with STOP_AT_ZERO=1 -> 00:00.00 held, zero_o=1, no wrap. Repeat with STOP_AT_ZERO=0 -> 59:59.99 with a wrap_o pulse.
- load_sec=8'h7A, load_min=8'h9F, load_frac=8'h3C -> sec_o=8'h59, min_o=8'h59, frac_o=8'h39.
- Count to 00:12.34, assert lap together with en -> lap_sec_o=8'h12, lap_frac_o=8'h34, frac_o=8'h35, lap_valid_o=1. Then clr+load+en in the same cycle -> everything 0, lap_valid_o=0.
- Assert rst low between clock edges mid-count -> outputs clear before the next edge. Release rst, 1 en -> frac_o=8'h01.
